// File: rtl/urv_console_pkg.sv
// Shared constants for the uRV AHB console: register offsets, STATUS bit positions,
// HTRANS encodings and the AHB slave FSM state type.
package urv_console_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_HALT   = 2'd3;

    localparam int ST_TX_EMPTY  = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_RX_VALID  = 3;
    localparam int ST_LEVEL_LSB = 8;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        AHB_IDLE,
        AHB_DPHASE,
        AHB_STALL
    } ahb_state_t;

endpackage

// File: rtl/urv_sync_fifo.sv
// Synchronous FIFO with level count; rst is active-low and sampled on wclk.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module urv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       wclk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge wclk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wclk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ahb_console_fifo.sv
// AHB-Lite console slave: DATA/STATUS/CTRL/HALT registers in front of a TX byte FIFO.
// Optional one-byte RX holding register when CONSOLE_RX_EN is defined.
module ahb_console_fifo
    import urv_console_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter bit STALL_ON_FULL = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        HALT,
    output logic [7:0]  HALT_CODE
`ifdef CONSOLE_RX_EN
    ,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    ahb_state_t  state;
    logic        dph_write;
    logic [1:0]  dph_off;
    logic        dph_vld, stall, data_wr, tx_push, tx_pop;
    logic        tx_full, tx_empty, tx_en, ovf;
    logic [LW-1:0] tx_level;
    logic        rx_full;
    logic [7:0]  rx_hold;
    logic [31:0] status;
    logic        unused;

    assign unused = ^{HADDR[31:4], HADDR[1:0], HSIZE, HWDATA[31:8]};

    assign dph_vld  = (state != AHB_IDLE);
    assign TX_VALID = ~tx_empty & tx_en;
    assign tx_pop   = TX_VALID & TX_READY;
    // A DATA write into a full FIFO waits only if no pop frees a slot this cycle.
    assign stall    = STALL_ON_FULL & dph_vld & dph_write & (dph_off == REG_DATA)
                      & tx_full & ~tx_pop;
    assign HREADYOUT = ~stall;
    assign HRESP     = 1'b0;
    assign data_wr   = dph_vld & dph_write & ~stall;
    assign tx_push   = data_wr & (dph_off == REG_DATA);

    urv_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .wclk  (CLK),
        .rst   (nRST),
        .push  (tx_push),
        .wdata (HWDATA[7:0]),
        .pop   (tx_pop),
        .rdata (TX_DATA),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    always_comb begin
        status = '0;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_OVF]      = ovf;
        status[ST_RX_VALID] = rx_full;
        status[ST_LEVEL_LSB +: 8] = 8'(tx_level);
    end

    // Reads are zero-wait and reflect the state of the first data-phase cycle.
    always_comb begin
        HRDATA = '0;
        if (dph_vld && !dph_write) begin
            case (dph_off)
                REG_DATA:   HRDATA = {24'b0, rx_hold};
                REG_STATUS: HRDATA = status;
                REG_CTRL:   HRDATA = {31'b0, tx_en};
                default:    HRDATA = {23'b0, HALT, HALT_CODE};
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= AHB_IDLE;
            dph_write <= 1'b0;
            dph_off   <= REG_DATA;
            ovf       <= 1'b0;
            tx_en     <= 1'b1;
            HALT      <= 1'b0;
            HALT_CODE <= 8'h00;
        end else begin
            if (stall) begin
                state <= AHB_STALL;
            end else if (HREADY && HSEL && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)) begin
                state     <= AHB_DPHASE;
                dph_write <= HWRITE;
                dph_off   <= HADDR[3:2];
            end else begin
                state <= AHB_IDLE;
            end

            if (data_wr) begin
                case (dph_off)
                    REG_DATA:   if (tx_full && !tx_pop) ovf <= 1'b1;
                    REG_STATUS: if (HWDATA[ST_OVF]) ovf <= 1'b0;
                    REG_CTRL:   tx_en <= HWDATA[0];
                    default: begin
                        HALT      <= 1'b1;
                        HALT_CODE <= HWDATA[7:0];
                    end
                endcase
            end
        end
    end

`ifdef CONSOLE_RX_EN
    logic rx_rd;
    assign rx_rd    = dph_vld & ~dph_write & (dph_off == REG_DATA);
    assign RX_READY = ~rx_full;

    // A load in the same cycle as a DATA read keeps the new byte.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rx_full <= 1'b0;
            rx_hold <= 8'h00;
        end else if (RX_VALID && RX_READY) begin
            rx_full <= 1'b1;
            rx_hold <= RX_DATA;
        end else if (rx_rd) begin
            rx_full <= 1'b0;
            rx_hold <= 8'h00;
        end
    end
`else
    assign rx_full = 1'b0;
    assign rx_hold = 8'h00;
`endif

endmodule
